// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decode pipeline register with RISC-V immediate extraction and imm_type/illegal decode.
// Define DECODE_SKID_EN to add a one-entry skid buffer so in_ready is a pure register output.
module imm_decode_stage #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [REG_LEN-1:0] in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_LEN-1:0] out_pc,
  output logic [2:0]         imm_type,
  output logic [REG_LEN-1:0] imm_J,
  output logic [REG_LEN-1:0] imm_U,
  output logic [REG_LEN-1:0] imm_B,
  output logic [REG_LEN-1:0] imm_S,
  output logic [REG_LEN-1:0] imm_I,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic               illegal
);
  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  dtype;
  logic        dill;
  logic        cap;
  assign op = in_instr[6:0];
  assign dtype = op == 7'b1101111 ? 3'd0 :
                 (op == 7'b0110111 || op == 7'b0010111) ? 3'd1 :
                 op == 7'b1100011 ? 3'd2 :
                 op == 7'b0100011 ? 3'd3 :
                 (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011) ? 3'd4 : 3'd5;
  assign dill = dtype == 3'd5 && op != 7'b0110011;
  assign cap = in_valid && in_ready;
`ifdef DECODE_SKID_EN
  logic               skid_full;
  logic [31:0]        s_instr;
  logic [REG_LEN-1:0] s_pc;
  logic [2:0]         s_type;
  logic               s_ill;
  assign in_ready = !skid_full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      {i, out_pc, imm_type, illegal} <= {32'h13, {REG_LEN{1'b0}}, 3'd4, 1'b0};
      {s_instr, s_pc, s_type, s_ill} <= {32'h13, {REG_LEN{1'b0}}, 3'd4, 1'b0};
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_full || cap;
      skid_full <= 1'b0;
      if (skid_full)
        {i, out_pc, imm_type, illegal} <= {s_instr, s_pc, s_type, s_ill};
      else if (cap)
        {i, out_pc, imm_type, illegal} <= {in_instr, in_pc, dtype, dill};
    end else if (cap) begin
      skid_full <= 1'b1;
      {s_instr, s_pc, s_type, s_ill} <= {in_instr, in_pc, dtype, dill};
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      {i, out_pc, imm_type, illegal} <= {32'h13, {REG_LEN{1'b0}}, 3'd4, 1'b0};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      {i, out_pc, imm_type, illegal} <= {in_instr, in_pc, dtype, dill};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif
  assign opcode = i[6:0];
  assign rd     = i[11:7];
  assign funct3 = i[14:12];
  assign rs1    = i[19:15];
  assign rs2    = i[24:20];
  assign funct7 = i[31:25];
  assign imm_I  = REG_LEN'($signed(i[31:20]));
  assign imm_S  = REG_LEN'($signed({i[31:25], i[11:7]}));
  assign imm_B  = REG_LEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
  assign imm_U  = REG_LEN'($signed({i[31:12], 12'b0}));
  assign imm_J  = REG_LEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench for imm_decode_stage; honours DECODE_SKID_EN when defined.
module tb_imm_decode_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm_J, imm_U, imm_B, imm_S, imm_I;
  logic [2:0]  imm_type, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;

  imm_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .imm_type(imm_type), .imm_J(imm_J),
    .imm_U(imm_U), .imm_B(imm_B), .imm_S(imm_S), .imm_I(imm_I), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  t;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pass = 0, total = 0, waits = 0;

  task automatic chk(string n, logic [159:0] a, logic [159:0] x);
    total++;
    if (a === x) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, x);
  endtask

  // immediates built bit-by-bit from the field layouts, ordered {J,U,B,S,I}
  function automatic logic [159:0] imms(logic [31:0] x);
    logic [31:0] ii, ss, bb, uu, jj;
    ii = {{21{x[31]}}, x[30:20]};
    ss = {{21{x[31]}}, x[30:25], x[11:7]};
    bb = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
    uu = {x[31:12], 12'h000};
    jj = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
    return {jj, uu, bb, ss, ii};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_out: out_valid=1 pc=%h with nothing expected", out_pc);
      end else begin
        e = q[0];
        chk("out_pc", 160'(out_pc), 160'(e.pc));
        chk("imm_type", 160'(imm_type), 160'(e.t));
        chk("illegal", 160'(illegal), 160'(e.ill));
        chk("immediates", {imm_J, imm_U, imm_B, imm_S, imm_I}, imms(e.instr));
        chk("fields", 160'({funct7, rs2, rs1, funct3, rd, opcode}), 160'(e.instr));
        if (out_ready && !flush) void'(q.pop_front());
      end
    end
  end

  task automatic send(logic [31:0] ins, logic [31:0] pc, logic [2:0] t, logic il);
    exp_t x;
    int   n = 0;
    bit   acc = 0;
    x.instr = ins; x.pc = pc; x.t = t; x.ill = il;
    in_valid = 1; in_instr = ins; in_pc = pc;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready && !flush;
      if (acc) q.push_back(x);
      @(posedge clk); #1;
      n++;
    end
    waits += n - 1;
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: instr %h not accepted in %0d cycles", ins, n);
    end
    in_valid = 0;
  endtask

  exp_t bc[2];
  int   acc_cnt, k;
  bit   a;

  initial begin
    #22;
    chk("rst_out_valid", 160'(out_valid), 0);
    chk("rst_in_ready", 160'(in_ready), 1);
    chk("rst_imm_type", 160'(imm_type), 4);
    chk("rst_imms", {imm_J, imm_U, imm_B, imm_S, imm_I}, 0);
    chk("rst_rd_rs1", 160'({rd, rs1}), 0);
    chk("rst_illegal", 160'(illegal), 0);
    chk("rst_out_pc", 160'(out_pc), 0);
    rst_n = 1;
    @(posedge clk); #1;

    send(32'hFFF00093, 32'h0000_0000, 3'd4, 0);
    chk("latency_valid", 160'(out_valid), 1);
    chk("addi_imm_I", 160'(imm_I), 160'(32'hFFFFFFFF));
    send(32'hFFDFF06F, 32'h0000_0004, 3'd0, 0);
    chk("jal_imm_J", 160'(imm_J), 160'(32'hFFFFFFFC));
    send(32'h123452B7, 32'h0000_0008, 3'd1, 0);
    chk("lui_imm_U_rd", 160'({imm_U, rd}), 160'({32'h12345000, 5'd5}));
    send(32'h0000007F, 32'h0000_000C, 3'd5, 1);
    send(32'h00000033, 32'h0000_0010, 3'd5, 0);

    waits = 0;
    send(32'hFE112E23, 32'h100, 3'd3, 0);
    send(32'hFE000CE3, 32'h104, 3'd2, 0);
    send(32'h00001097, 32'h108, 3'd1, 0);
    send(32'h00012083, 32'h10C, 3'd4, 0);
    send(32'h000080E7, 32'h110, 3'd4, 0);
    send(32'h00000073, 32'h114, 3'd4, 0);
    send(32'h0000000F, 32'h118, 3'd5, 1);
    send(32'h80000037, 32'h11C, 3'd1, 0);
    chk("stream_stalls", 160'(waits), 0);
    repeat (3) @(posedge clk);
    #1 chk("stream_drained", 160'(q.size()), 0);

    out_ready = 0;
    send(32'hFE112E23, 32'h200, 3'd3, 0);
    bc[0].instr = 32'hFFF00093; bc[0].pc = 32'h204; bc[0].t = 3'd4; bc[0].ill = 0;
    bc[1].instr = 32'h123452B7; bc[1].pc = 32'h208; bc[1].t = 3'd1; bc[1].ill = 0;
    acc_cnt = 0; k = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_instr = bc[k].instr; in_pc = bc[k].pc;
      @(negedge clk);
      a = in_ready;
      if (a) begin q.push_back(bc[k]); acc_cnt++; end
      @(posedge clk); #1;
      if (a && k < 1) k++;
    end
`ifdef DECODE_SKID_EN
    chk("stall_accepts", 160'(acc_cnt), 1);
`else
    chk("stall_accepts", 160'(acc_cnt), 0);
`endif
    @(negedge clk);
    chk("stalled_in_ready", 160'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    #1 chk("stall_drained", 160'(q.size()), 0);

    out_ready = 0;
    send(32'h00012083, 32'h300, 3'd4, 0);
    in_valid = 1; in_instr = 32'hFFDFF06F; in_pc = 32'h304; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; q.delete();
    chk("flush_out_valid", 160'(out_valid), 0);
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk("flush_no_ghost", 160'(out_valid), 0);

    send(32'h00001097, 32'h400, 3'd1, 0);
    in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'h404;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 160'(out_valid), 0);
    chk("midrst_imm_type", 160'(imm_type), 4);
    chk("midrst_in_ready", 160'(in_ready), 1);
    q.delete(); in_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
    send(32'hFFF00093, 32'h500, 3'd4, 0);
    chk("post_rst_capture", 160'(out_valid), 1);
    repeat (3) @(posedge clk);
    #1 chk("final_drained", 160'(q.size()), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
